// File: rtl/sprite_ram_loader.sv
// Unpacks CPU pixel words LSB-first onto the sprite RAM write port, one pixel per clock.
// Optional running write checksum is built when SPRITE_LOADER_CHECKSUM_EN is defined.
module sprite_ram_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 2,
    parameter int WORD_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cmd_start,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [ADDR_WIDTH-1:0] cmd_len,
    input  logic                  wr_valid,
    input  logic [WORD_WIDTH-1:0] wr_data,
    output logic                  wr_ready,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] addr_w,
    output logic [DATA_WIDTH-1:0] din,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           checksum
);

    localparam int PIX_PER_WORD = WORD_WIDTH / DATA_WIDTH;
    localparam int CNT_W        = $clog2(PIX_PER_WORD + 1);
    localparam logic [CNT_W-1:0]    PIX_LAST  = CNT_W'(PIX_PER_WORD);
    localparam logic [ADDR_WIDTH:0] FULL_LEN  = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
    logic [ADDR_WIDTH:0]   remaining_q, remaining_d;
    logic [CNT_W-1:0]      pix_cnt_q, pix_cnt_d;
    logic [WORD_WIDTH-1:0] shift_q, shift_d;
    logic                  wr_ready_q, wr_ready_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_w_q, addr_w_d;
    logic [DATA_WIDTH-1:0] din_q, din_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [15:0]           checksum_q, checksum_d;

    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        pix_cnt_d   = pix_cnt_q;
        shift_d     = shift_q;
        we_d        = 1'b0;
        addr_w_d    = addr_w_q;
        din_d       = din_q;
        checksum_d  = checksum_q;

        case (state_q)
            IDLE: begin
                if (cmd_start) begin
                    cur_addr_d  = cmd_addr;
                    remaining_d = (cmd_len == '0) ? FULL_LEN : {1'b0, cmd_len};
                    checksum_d  = 16'h0000;
                    state_d     = LOAD;
                end
            end
            LOAD: begin
                if (wr_valid && wr_ready_q) begin
                    shift_d   = wr_data;
                    pix_cnt_d = '0;
                    state_d   = WRITE;
                end
            end
            WRITE: begin
                we_d        = 1'b1;
                addr_w_d    = cur_addr_q;
                din_d       = shift_q[DATA_WIDTH-1:0];
                checksum_d  = {checksum_q[14:0], checksum_q[15]}
                              ^ {{(16-DATA_WIDTH){1'b0}}, shift_q[DATA_WIDTH-1:0]};
                shift_d     = shift_q >> DATA_WIDTH;
                cur_addr_d  = cur_addr_q + ADDR_WIDTH'(1);
                remaining_d = remaining_q - (ADDR_WIDTH+1)'(1);
                pix_cnt_d   = pix_cnt_q + CNT_W'(1);
                // Length exhaustion wins: leftover pixels of the word are dropped.
                if (remaining_d == '0) begin
                    state_d = DONE;
                end else if (pix_cnt_d == PIX_LAST) begin
                    state_d = LOAD;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Flags are registered from the next state so they line up with the state they describe.
        wr_ready_d = (state_d == LOAD);
        busy_d     = (state_d != IDLE);
        done_d     = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            pix_cnt_q   <= '0;
            shift_q     <= '0;
            wr_ready_q  <= 1'b0;
            we_q        <= 1'b0;
            addr_w_q    <= '0;
            din_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            checksum_q  <= 16'h0000;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
            pix_cnt_q   <= pix_cnt_d;
            shift_q     <= shift_d;
            wr_ready_q  <= wr_ready_d;
            we_q        <= we_d;
            addr_w_q    <= addr_w_d;
            din_q       <= din_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            checksum_q  <= checksum_d;
        end
    end

    assign wr_ready = wr_ready_q;
    assign we       = we_q;
    assign addr_w   = addr_w_q;
    assign din      = din_q;
    assign busy     = busy_q;
    assign done     = done_q;

`ifdef SPRITE_LOADER_CHECKSUM_EN
    assign checksum = checksum_q;
`else
    assign checksum = 16'h0000;
`endif

endmodule

// File: tb/tb_sprite_ram_loader.sv
// Directed + randomized checks of sprite_ram_loader against a pixel-list reference model.
// Honours SPRITE_LOADER_CHECKSUM_EN the same way the design does.
module tb_sprite_ram_loader;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_start = 1'b0;
    logic [7:0]  cmd_addr = 8'h00;
    logic [7:0]  cmd_len = 8'h00;
    logic        wr_valid = 1'b0;
    logic [31:0] wr_data = 32'h0;
    logic        wr_ready, we, busy, done;
    logic [7:0]  addr_w;
    logic [1:0]  din;
    logic [15:0] checksum;

    int checks = 0;
    int errors = 0;

    sprite_ram_loader #(.ADDR_WIDTH(8), .DATA_WIDTH(2), .WORD_WIDTH(32)) dut (
        .clk(clk), .reset_n(reset_n), .cmd_start(cmd_start), .cmd_addr(cmd_addr),
        .cmd_len(cmd_len), .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .we(we), .addr_w(addr_w), .din(din), .busy(busy), .done(done), .checksum(checksum)
    );

    always #5 clk = ~clk;

    // Passive monitor: records every RAM write and a few protocol counters.
    int         cyc = 0;
    logic [7:0] obs_addr[$];
    logic [1:0] obs_din[$];
    int         obs_cyc[$];
    int         done_cnt = 0;
    int         ready_rises = 0;
    int         viol = 0;
    logic       prev_ready = 1'b0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (we) begin
            obs_addr.push_back(addr_w);
            obs_din.push_back(din);
            obs_cyc.push_back(cyc);
        end
        if (done) done_cnt = done_cnt + 1;
        if (wr_ready && !prev_ready) ready_rises = ready_rises + 1;
        if ((wr_ready && (!busy || done)) || (done && !busy) || (we && !busy)) viol = viol + 1;
        prev_ready = wr_ready;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout observed=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_load(input logic [7:0] a, input logic [7:0] l, input int stall,
                            input bit use_fixed, input logic [31:0] fixed, input bit inject);
        logic [31:0] words[16];
        logic [31:0] tmp;
        logic [15:0] cs;
        logic [7:0]  ea;
        logic [1:0]  ep;
        int leff, nw, base, d0, r0, bound, n;
        leff = (l == 8'd0) ? 256 : int'(l);
        nw   = (leff + 15) / 16;
        for (int k = 0; k < 16; k++) words[k] = use_fixed ? fixed : $urandom;
        base = obs_addr.size();
        d0   = done_cnt;
        r0   = ready_rises;

        cmd_addr = a; cmd_len = l; cmd_start = 1'b1;
        @(negedge clk);
        cmd_start = 1'b0; cmd_addr = 8'($urandom); cmd_len = 8'($urandom);
        chk("busy_rise", {31'b0, busy}, 32'd1);

        for (int k = 0; k < nw; k++) begin
            repeat (stall) @(negedge clk);
            wr_valid = 1'b1; wr_data = words[k];
            bound = 0;
            while (!wr_ready && bound < 100) begin
                @(negedge clk);
                bound++;
            end
            chk("wr_ready_wait", {31'b0, wr_ready}, 32'd1);
            @(negedge clk);
            wr_valid = 1'b0; wr_data = $urandom;
            if (inject && k == 0) begin
                cmd_start = 1'b1; cmd_addr = a + 8'h80; cmd_len = 8'd5;
                @(negedge clk);
                cmd_start = 1'b0;
            end
        end

        bound = 0;
        while (!done && bound < 100) begin
            @(negedge clk);
            bound++;
        end
        chk("done_seen", {31'b0, done}, 32'd1);
        @(negedge clk);
        chk("busy_after", {31'b0, busy}, 32'd0);
        chk("done_pulse_width", {31'b0, done}, 32'd0);

        n = obs_addr.size() - base;
        chk("write_count", n, leff);
        cs = 16'h0;
        if (n == leff) begin
            for (int i = 0; i < leff; i++) begin
                ea  = a + 8'(i);
                tmp = words[i / 16] >> (2 * (i % 16));
                ep  = tmp[1:0];
                cs  = {cs[14:0], cs[15]} ^ {14'b0, ep};
                chk("wr_addr", {24'b0, obs_addr[base + i]}, {24'b0, ea});
                chk("wr_din", {30'b0, obs_din[base + i]}, {30'b0, ep});
            end
            if (nw == 1) chk("consecutive", obs_cyc[base + leff - 1] - obs_cyc[base], leff - 1);
        end
`ifndef SPRITE_LOADER_CHECKSUM_EN
        cs = 16'h0;
`endif
        chk("checksum", {16'b0, checksum}, {16'b0, cs});
        chk("done_count", done_cnt - d0, 1);
        chk("ready_rises", ready_rises - r0, nw);
        chk("protocol_viol", viol, 0);
        $display("load addr=%02h len=%0d words=%0d writes=%0d checksum=%04h", a, leff, nw, n, checksum);
    endtask

    initial begin
        int bound;
        // Reset held with random inputs.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            cmd_start = 1'($urandom); cmd_addr = 8'($urandom); cmd_len = 8'($urandom);
            wr_valid = 1'($urandom); wr_data = $urandom;
            #1;
            chk("rst_outputs", {22'b0, wr_ready, we, busy, done, addr_w, din},
                32'd0);
            chk("rst_checksum", {16'b0, checksum}, 32'd0);
        end
        @(negedge clk);
        cmd_start = 1'b0; wr_valid = 1'b0;
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_after_rst", {30'b0, busy, wr_ready}, 32'd0);

        run_load(8'h10, 8'd16, 0, 1'b1, 32'hE4E4E4E4, 1'b0);
        run_load(8'hFC, 8'd8, 0, 1'b1, 32'h0000FFFF, 1'b0);
        run_load(8'h00, 8'd0, 3, 1'b0, 32'h0, 1'b0);
        run_load(8'h40, 8'd32, 1, 1'b0, 32'h0, 1'b1);

        // Reset pulse in the middle of a write burst.
        cmd_addr = 8'h20; cmd_len = 8'd40; cmd_start = 1'b1;
        @(negedge clk);
        cmd_start = 1'b0;
        wr_valid = 1'b1; wr_data = $urandom;
        bound = 0;
        while (!wr_ready && bound < 100) begin
            @(negedge clk);
            bound++;
        end
        @(negedge clk);
        wr_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("we_before_abort", {31'b0, we}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("abort_we", {31'b0, we}, 32'd0);
        chk("abort_wr_ready", {31'b0, wr_ready}, 32'd0);
        chk("abort_busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        run_load(8'h33, 8'd20, 2, 1'b0, 32'h0, 1'b0);

        run_load(8'h00, 8'd2, 0, 1'b1, 32'h00000006, 1'b0);
`ifdef SPRITE_LOADER_CHECKSUM_EN
        chk("checksum_literal", {16'b0, checksum}, 32'h0005);
`else
        chk("checksum_literal", {16'b0, checksum}, 32'h0000);
`endif

        for (int t = 0; t < 4; t++) begin
            run_load(8'($urandom), 8'($urandom_range(60, 1)), int'($urandom_range(3, 0)),
                     1'b0, 32'h0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
